// File: rtl/sram_pkg.sv
// Shared constants and word type for the 1M x 32 frame-buffer SRAM and its users.
package sram_pkg;

  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = 1024 * 1024;
  localparam int ADDR_SZ   = 20;

  typedef logic [RAM_WIDTH-1:0] sram_word_t;

endpackage : sram_pkg

// File: rtl/sram_1mx32.sv
// Single-port synchronous SRAM, read-first, registered read port; maps to block RAM
// plus its output register. Reset clears only the output register.
module sram_1mx32
  import sram_pkg::*;
#(
  parameter int DATA_W = RAM_WIDTH,
  parameter int ADDR_W = ADDR_SZ,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // NOTE: the array has no reset term; resetting it would stop synthesis from
  // inferring block RAM. rst only qualifies the write so a low rst blocks it.
  always_ff @(posedge clk) begin
    if (en && we && rst) begin
      mem[addr] <= data_in;
    end
  end

  // NOTE: non-blocking reads of mem here see the pre-edge contents, which is
  // exactly the read-first behaviour on a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else if (en) begin
      data_out <= mem[addr];
    end
  end

endmodule : sram_1mx32

// File: tb/tb_sram_1mx32.sv
// Self-checking bench for sram_1mx32: directed scenarios plus a randomized
// read/write mix scored against an associative-array memory model.
module tb_sram_1mx32;
  import sram_pkg::*;

  localparam int N = 128;  // rotation region edge

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               we;
  logic [ADDR_SZ-1:0] addr;
  sram_word_t         data_in;
  sram_word_t         data_out;

  int n_tests = 0;
  int n_fail  = 0;

  sram_word_t model [int];
  sram_word_t exp_q;

  sram_1mx32 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input sram_word_t obs, input sram_word_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access, clock it, and return 1 time unit after the edge.
  task automatic access(input logic e, input logic w, input int a, input sram_word_t d);
    en      = e;
    we      = w;
    addr    = ADDR_SZ'(a);
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    @(posedge clk); #1;

    // Reset: asynchronous clear, writes blocked, memory retained.
    access(1, 1, 0, 32'h1234_5678);
    access(1, 0, 0, 32'h0);
    check("preload_read", data_out, 32'h1234_5678);
    #2 rst = 1'b0;
    #1 check("reset_async", data_out, 32'h0);
    access(1, 1, 0, 32'hFFFF_FFFF);
    check("reset_hold_1", data_out, 32'h0);
    access(1, 0, 0, 32'h0);
    check("reset_hold_2", data_out, 32'h0);
    #2 rst = 1'b1;
    access(1, 0, 0, 32'h0);
    check("reset_mem_kept", data_out, 32'h1234_5678);
    model[0] = 32'h1234_5678;

    // Write then read.
    access(1, 1, 'h00102, 32'h00AB_CDEF);
    access(1, 0, 'h00102, 32'h0);
    check("wr_rd", data_out, 32'h00AB_CDEF);

    // Read-first collision.
    access(1, 1, 'h00005, 32'h1111_1111);
    access(1, 1, 'h00005, 32'h2222_2222);
    check("rdw_old", data_out, 32'h1111_1111);
    access(1, 0, 'h00005, 32'h0);
    check("rdw_new", data_out, 32'h2222_2222);

    // Enable gating: memory and data_out both frozen.
    access(1, 1, 'h00010, 32'h0);
    access(1, 0, 'h00005, 32'h0);
    access(0, 1, 'h00010, 32'hDEAD_BEEF);
    check("en0_hold", data_out, 32'h2222_2222);
    access(0, 0, 'h00102, 32'h0);
    check("en0_hold2", data_out, 32'h2222_2222);
    access(1, 0, 'h00010, 32'h0);
    check("en0_no_write", data_out, 32'h0);

    // Boundary addresses, no aliasing.
    access(1, 1, 'hFFFFF, 32'hA5A5_A5A5);
    access(1, 1, 'h00000, 32'h5A5A_5A5A);
    access(1, 0, 'hFFFFF, 32'h0);
    check("addr_max", data_out, 32'hA5A5_A5A5);
    access(1, 0, 'h00000, 32'h0);
    check("addr_min", data_out, 32'h5A5A_5A5A);
    access(1, 0, 'h7FFFF, 32'h0);
    access(1, 0, 'h80000, 32'h0);

    // Randomized mix over a small address pool, scored against the model.
    begin
      int pool [16];
      int fails_before;
      for (int i = 0; i < 16; i++) begin
        pool[i] = int'($urandom_range(0, RAM_DEPTH - 1));
        if (i == 0) pool[i] = 0;
        if (i == 1) pool[i] = RAM_DEPTH - 1;
        model[pool[i]] = sram_word_t'($urandom);
        access(1, 1, pool[i], model[pool[i]]);
      end
      exp_q = data_out;
      fails_before = n_fail;
      for (int i = 0; i < 2000; i++) begin
        int         a;
        logic       e;
        logic       w;
        sram_word_t d;
        a = pool[$urandom_range(0, 15)];
        e = ($urandom_range(0, 3) != 0);
        w = $urandom_range(0, 1) == 1;
        d = sram_word_t'($urandom);
        if (e) begin
          exp_q = model[a];
          if (w) model[a] = d;
        end
        access(e, w, a, d);
        if (n_fail - fails_before < 10) check("random", data_out, exp_q);
        else begin
          n_tests++;
          if (data_out !== exp_q) n_fail++;
        end
      end
    end

    // Rotation sweep: fill {x,y} with {x,y}, read back rotated in raster order.
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        access(1, 1, (x << 8) | y, sram_word_t'((x << 8) | y));
    begin
      int fails_before;
      fails_before = n_fail;
      for (int x = 0; x < N; x++)
        for (int y = 0; y < N; y++) begin
          int ra;
          ra = (y << 8) | (N - 1 - x);
          access(1, 0, ra, 32'h0);
          if (n_fail - fails_before < 10) check("rotate", data_out, sram_word_t'(ra));
          else begin
            n_tests++;
            if (data_out !== sram_word_t'(ra)) n_fail++;
          end
        end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sram_1mx32
